combination_accumulator: RTL
============================

Name: combination_accumulator

Overview:
Parametrised successor to the existing combination counter. Counts occurrences of every channel combination (a CHANNELS-bit mask) in an on-chip RAM of depth 2^CHANNELS, with a popcount filter and automatic clear sweeps. Provides a drain/readout state machine that streams all bins out over a valid/ready handshake, with optional clear-on-read. Sits after the combination-window detector and feeds the host readout path.

Parameters:
CHANNELS, 8, combination mask width; RAM depth 2^CHANNELS; legal range 4..16.
ACC_WIDTH, 32, width of each bin counter.
CLEAR_ON_READ, 0, 1: each bin is written to zero as it is read out.

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
s_comb_valid  in  1  combination event valid
s_comb_ready  out  1  event accepted when valid&ready
s_comb_value  in  CHANNELS  combination mask
filter_min  in  $clog2(CHANNELS+1)  minimum popcount counted
filter_max  in  $clog2(CHANNELS+1)  maximum popcount counted
capture_enable  in  1  1: accepted events are counted
reset_comb  in  1  pulse: clear all bins and the overflow flag
reset_comb_done  out  1  one-cycle pulse when a clear sweep finishes
start_reading  in  1  pulse: start readout
m_valid  out  1  readout word valid
m_ready  in  1  readout backpressure
m_value  out  CHANNELS  bin address (combination mask)
m_count  out  ACC_WIDTH  bin count
m_last  out  1  high on final bin (address 2^CHANNELS-1)
overflow  out  1  sticky counter overflow

Behaviour:
- Reset (rst_n low, async): all outputs 0; state CLEAR, clear address 0. After release, the CLEAR sweep runs automatically.
- States: CLEAR, IDLE, DRAIN, READOUT.
- CLEAR: writes 0 to one address per cycle, 0..2^CHANNELS-1 (2^CHANNELS cycles). s_comb_ready=0. On the final write: reset_comb_done=1 for one cycle, overflow cleared, go to IDLE.
- IDLE: s_comb_ready=1. An accepted event is counted only if capture_enable=1, value!=0, and filter_min<=popcount(value)<=filter_max; otherwise it is dropped silently.
- Count pipeline: RAM read in the accept cycle t; increment and write-back at t+1; bin visible in RAM from t+2. Back-to-back hits on the same bin must forward so that N consecutive hits add exactly N. Throughput: 1 event per cycle.
- Arithmetic: count+1 modulo 2^ACC_WIDTH. A transition from all-ones sets overflow (sticky until the next CLEAR).
- start_reading in IDLE with capture_enable=0: go to DRAIN and drop s_comb_ready the next cycle. start_reading is ignored if capture_enable=1 or the state is not IDLE.
- DRAIN: wait until the count pipeline is empty (at most 2 cycles), then go to READOUT.
- READOUT: streams addresses 0..2^CHANNELS-1 in order. m_value=address; m_count=bin; first m_valid no later than 3 cycles after start_reading. Outputs hold while m_valid&!m_ready. m_last is set with the final word. After the final handshake, return to IDLE. With CLEAR_ON_READ=1, each bin is zeroed in the cycle its word handshakes.
- reset_comb in any state: aborts the current activity; m_valid=0 next cycle; in-flight increments are discarded; enter CLEAR at address 0. A reset_comb during CLEAR restarts the sweep.
- reset_comb and start_reading in the same cycle: reset_comb wins.
- Filter with filter_min>filter_max: no event is counted.

Optional Feature:
COMBINATION_ACC_SATURATE_EN
- Defined: bins saturate at 2^ACC_WIDTH-1 instead of wrapping; overflow is still set on the first saturating hit.
- Undefined: modulo wrap as described above.

Test Plan:
- Release rst_n, CHANNELS=8 -> s_comb_ready=0 for 256 cycles, then one reset_comb_done pulse, then s_comb_ready=1; an immediate readout returns 256 words, all count 0, m_last on 0xFF.
- filter_min=2, filter_max=3, capture_enable=1; send 0x03 ×5, 0x01 ×4, 0x07 ×2, 0x0F ×1, 0x00 ×1; then readout -> bin 0x03=5, 0x07=2, all others 0.
- 10 back-to-back events of 0xA5 with no gaps (popcount 4, filter 0..8) -> bin 0xA5=10, confirming forwarding.
- Readout with m_ready toggled randomly -> 256 words in address order, none lost or duplicated. With CLEAR_ON_READ=1, a second readout returns all zeros.
- ACC_WIDTH=4; 17 hits on 0x11 -> without the macro: count 1, overflow=1. With COMBINATION_ACC_SATURATE_EN: count 15, overflow=1. A subsequent reset_comb clears overflow.
- reset_comb asserted at readout word 40 -> m_valid=0 next cycle, full 256-cycle sweep, reset_comb_done pulse, then a readout returns all zeros.

Source files
------------

// File: rtl/combination_accumulator.sv
// combination_accumulator
//   Counts occurrences of every CHANNELS-bit combination mask in an on-chip
//   RAM of 2^CHANNELS bins. Events pass a popcount window filter before they
//   are counted. A clear sweep runs after reset and on reset_comb. A readout
//   engine streams every bin over a valid/ready handshake and can optionally
//   zero each bin as it is read.
//
//   Optional build macro: COMBINATION_ACC_SATURATE_EN
//     defined   -> bins saturate at all-ones (overflow still flagged)
//     undefined -> bins wrap modulo 2^ACC_WIDTH
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     s_comb_valid/ready/value   combination event input (valid/ready)
//     filter_min/max    inclusive popcount window for counted events
//     capture_enable    1: accepted events are counted
//     reset_comb        pulse: clear all bins and overflow
//     reset_comb_done   one-cycle pulse on the final clear write
//     start_reading     pulse: start readout (IDLE and capture_enable=0 only)
//     m_valid/ready     readout handshake
//     m_value/count     bin address and bin count
//     m_last            final bin (address all-ones)
//     overflow          sticky counter overflow
module combination_accumulator #(
   parameter int CHANNELS      = 8,
   parameter int ACC_WIDTH     = 32,
   parameter int CLEAR_ON_READ = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             s_comb_valid,
   output logic                             s_comb_ready,
   input  logic [CHANNELS-1:0]              s_comb_value,
   input  logic [$clog2(CHANNELS+1)-1:0]    filter_min,
   input  logic [$clog2(CHANNELS+1)-1:0]    filter_max,
   input  logic                             capture_enable,
   input  logic                             reset_comb,
   output logic                             reset_comb_done,
   input  logic                             start_reading,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [CHANNELS-1:0]              m_value,
   output logic [ACC_WIDTH-1:0]             m_count,
   output logic                             m_last,
   output logic                             overflow
);

   localparam int FW    = $clog2(CHANNELS+1);
   localparam int DEPTH = 1 << CHANNELS;

   typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_DRAIN, ST_READOUT} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [CHANNELS-1:0]   r_addr;
   logic                  r_m_valid;
   logic                  r_p1_valid;
   logic [CHANNELS-1:0]   r_p1_addr;
   logic                  r_fw_valid;
   logic [CHANNELS-1:0]   r_fw_addr;
   logic [ACC_WIDTH-1:0]  r_fw_data;
   logic                  r_overflow;
   logic [ACC_WIDTH-1:0]  r_mem [DEPTH];
   logic [ACC_WIDTH-1:0]  r_rd_data;

   logic [FW-1:0]         w_pop;
   logic                  w_hit;
   logic                  w_addr_last;
   logic                  w_handshake;
   logic [ACC_WIDTH-1:0]  w_old;
   logic [ACC_WIDTH-1:0]  w_inc;
   logic                  w_wrap;
   logic                  w_inc_we;
   logic                  w_we;
   logic [CHANNELS-1:0]   w_waddr;
   logic [ACC_WIDTH-1:0]  w_wdata;
   logic [CHANNELS-1:0]   w_raddr;

   always_comb begin
      w_pop = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         w_pop = w_pop + FW'(s_comb_value[i]);
      end
   end

   assign s_comb_ready = (r_state == ST_IDLE);
   assign w_addr_last  = (r_addr == '1);
   assign w_handshake  = r_m_valid & m_ready;

   // reset_comb in the accept cycle discards the event as well.
   assign w_hit = s_comb_valid & s_comb_ready & capture_enable & (|s_comb_value)
                & (w_pop >= filter_min) & (w_pop <= filter_max) & ~reset_comb;

   // The RAM read issued in the accept cycle misses the write-back of the
   // immediately preceding event; take that value from the bypass register.
   assign w_old    = (r_fw_valid && (r_fw_addr == r_p1_addr)) ? r_fw_data : r_rd_data;
   assign w_wrap   = &w_old;
   assign w_inc_we = r_p1_valid & ~reset_comb;

`ifdef COMBINATION_ACC_SATURATE_EN
   assign w_inc = w_wrap ? w_old : w_old + ACC_WIDTH'(1);
`else
   assign w_inc = w_old + ACC_WIDTH'(1);
`endif

   // Single write port: clear sweep, clear-on-read, or count write-back.
   // Write-back only occurs in IDLE/DRAIN, so the sources never collide.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_addr;
      w_wdata = '0;
      if (r_state == ST_CLEAR) begin
         w_we = 1'b1;
      end
      if ((r_state == ST_READOUT) && (CLEAR_ON_READ != 0) && w_handshake) begin
         w_we = 1'b1;
      end
      if (w_inc_we) begin
         w_we    = 1'b1;
         w_waddr = r_p1_addr;
         w_wdata = w_inc;
      end
   end

   // Readout re-reads the current address while stalled so m_count holds.
   always_comb begin
      w_raddr = '0;
      case (r_state)
         ST_IDLE:    w_raddr = s_comb_value;
         ST_READOUT: w_raddr = (w_handshake && !w_addr_last) ? r_addr + CHANNELS'(1) : r_addr;
         default:    w_raddr = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
      r_rd_data <= r_mem[w_raddr];
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_CLEAR:   if (w_addr_last) w_next = ST_IDLE;
         ST_IDLE:    if (start_reading && !capture_enable) w_next = ST_DRAIN;
         ST_DRAIN:   if (!r_p1_valid) w_next = ST_READOUT;
         ST_READOUT: if (w_handshake && w_addr_last) w_next = ST_IDLE;
         default:    w_next = ST_CLEAR;
      endcase
      if (reset_comb) begin
         w_next = ST_CLEAR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_CLEAR;
         r_addr     <= '0;
         r_m_valid  <= 1'b0;
         r_p1_valid <= 1'b0;
         r_p1_addr  <= '0;
         r_fw_valid <= 1'b0;
         r_fw_addr  <= '0;
         r_fw_data  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_p1_valid <= w_hit;
         r_p1_addr  <= s_comb_value;
         r_fw_valid <= w_inc_we;
         r_fw_addr  <= r_p1_addr;
         r_fw_data  <= w_inc;
         if (w_inc_we && w_wrap) begin
            r_overflow <= 1'b1;
         end
         if (reset_comb) begin
            r_addr    <= '0;
            r_m_valid <= 1'b0;
         end else begin
            case (r_state)
               ST_CLEAR: begin
                  r_addr <= r_addr + CHANNELS'(1);
                  if (w_addr_last) r_overflow <= 1'b0;
               end
               ST_DRAIN: begin
                  if (!r_p1_valid) begin
                     r_addr    <= '0;
                     r_m_valid <= 1'b1;
                  end
               end
               ST_READOUT: begin
                  if (w_handshake) begin
                     r_addr <= r_addr + CHANNELS'(1);
                     if (w_addr_last) r_m_valid <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign reset_comb_done = (r_state == ST_CLEAR) & w_addr_last & ~reset_comb;
   assign m_valid  = r_m_valid;
   assign m_value  = r_m_valid ? r_addr : '0;
   assign m_count  = r_m_valid ? r_rd_data : '0;
   assign m_last   = r_m_valid & w_addr_last;
   assign overflow = r_overflow;

endmodule
